// File: rtl/ready_seq_gen_pkg.sv
// Shared types and helpers for the ready/readyp handshake sequencer.
package ready_seq_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        RDY,
        RDYP
    } seq_state_t;

    // Phase lengths of zero still give the phase one cycle.
    function automatic int unsigned len_sat1(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

endpackage

// File: rtl/ready_seq_gen_if.sv
// Handshake/config bundle between a stimulus controller and ready_seq_gen.
interface ready_seq_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] lead_cycles;
    logic [CNT_W-1:0] ready_len;
    logic [CNT_W-1:0] readyp_len;
    logic             ready;
    logic             readyp;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, lead_cycles, ready_len, readyp_len,
        input  ready, readyp, busy, done
    );

    modport slave (
        input  start, abort, lead_cycles, ready_len, readyp_len,
        output ready, readyp, busy, done
    );
endinterface

// File: rtl/ready_seq_gen_phase_counter.sv
// Loadable down counter that flags the last cycle of a sequencer phase.
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/ready_seq_gen.sv
// Programmable lead / ready / readyp / done sequencer with registered outputs.
// Build option READY_HOLD_EN keeps ready asserted through the readyp phase.
module ready_seq_gen
    import ready_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    ready_seq_gen_if.slave   bus
);
    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] r_len, p_len;
    logic             cap;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             en;
    logic             expire;
    logic             ready_q, readyp_q, busy_q, done_q;
    logic             ready_nxt, readyp_nxt, busy_nxt, done_nxt;

    phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (ld_val),
        .en       (en),
        .expire   (expire)
    );

    assign en = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        ld        = 1'b0;
        ld_val    = '0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    cap = 1'b1;
                    ld  = 1'b1;
                    if (bus.lead_cycles != '0) begin
                        state_nxt = LEAD;
                        ld_val    = bus.lead_cycles;
                    end else begin
                        // No lead-in: the ready phase uses the live length directly
                        state_nxt = RDY;
                        ld_val    = CNT_W'(len_sat1(32'(bus.ready_len)));
                    end
                end
            end
            LEAD: if (expire) begin
                state_nxt = RDY;
                ld        = 1'b1;
                ld_val    = r_len;
            end
            RDY: if (expire) begin
                state_nxt = RDYP;
                ld        = 1'b1;
                ld_val    = p_len;
            end
            RDYP: if (expire) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if ((state != IDLE) && bus.abort) begin
            state_nxt = IDLE;
            ld        = 1'b0;
            done_nxt  = 1'b0;
        end

`ifdef READY_HOLD_EN
        ready_nxt  = (state_nxt == RDY) || (state_nxt == RDYP);
`else
        ready_nxt  = (state_nxt == RDY);
`endif
        readyp_nxt = (state_nxt == RDYP);
        busy_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            readyp_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_q  <= ready_nxt;
            readyp_q <= readyp_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // Phase lengths are frozen at the accepting start edge
    always_ff @(posedge clk) begin
        if (cap) begin
            r_len <= CNT_W'(len_sat1(32'(bus.ready_len)));
            p_len <= CNT_W'(len_sat1(32'(bus.readyp_len)));
        end
    end

    assign bus.ready  = ready_q;
    assign bus.readyp = readyp_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_ready_seq_gen.sv
// Scoreboard bench for ready_seq_gen: expected {ready,readyp,busy,done} per edge.
module tb_ready_seq_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ready_seq_gen_if #(.CNT_W(8)) bus();

    ready_seq_gen #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [3:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b (ready,readyp,busy,done) t=%0t", tag, got, exp, $time);
        end
    endtask

    // Outputs after edge N+k for a sequence accepted at edge N
    function automatic logic [3:0] model(input int k, input int l, input int r, input int p);
        int   rr;
        int   pp;
        logic rd, rp, bz, dn;
        rr = (r == 0) ? 1 : r;
        pp = (p == 0) ? 1 : p;
        bz = (k < l + rr + pp);
        rp = (k >= l + rr) && bz;
`ifdef READY_HOLD_EN
        rd = (k >= l) && bz;
`else
        rd = (k >= l) && (k < l + rr);
`endif
        dn = (k == l + rr + pp);
        return {rd, rp, bz, dn};
    endfunction

    task automatic tick(input logic [3:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            string      t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {bus.ready, bus.readyp, bus.busy, bus.done}, e);
        end
    end

    task automatic run(input string tag, input int l, input int r, input int p, input int nt,
                       input int restart_at, input int abort_at, input int rst_at, input int cfg_at);
        bit killed;
        killed = 1'b0;
        bus.lead_cycles = 8'(l);
        bus.ready_len   = 8'(r);
        bus.readyp_len  = 8'(p);
        for (int k = 0; k < nt; k++) begin
            bus.start = (k == 0) || (k == restart_at);
            bus.abort = (k == abort_at);
            rst_n     = !(k == rst_at);
            if (k == cfg_at) begin
                bus.lead_cycles = 8'd200;
                bus.ready_len   = 8'd1;
                bus.readyp_len  = 8'd2;
            end
            if ((k == abort_at) || (k == rst_at)) killed = 1'b1;
            tick(killed ? 4'b0000 : model(k, l, r, p), $sformatf("%s_k%0d", tag, k));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.lead_cycles = '0;
        bus.ready_len   = '0;
        bus.readyp_len  = '0;
        tick(4'b0000, "reset0");
        tick(4'b0000, "reset1");
        rst_n = 1'b1;
        tick(4'b0000, "idle");

        run("base", 4, 3, 10, 19, -1, -1, -1, -1);
        run("zero", 0, 0, 0, 4, -1, -1, -1, -1);
        run("restart_cfg", 4, 3, 10, 19, 2, -1, -1, 1);
        run("chainA", 2, 2, 2, 7, -1, -1, -1, -1);
        run("chainB", 0, 1, 1, 4, -1, -1, -1, -1);
        run("abort_rdyp", 4, 3, 10, 19, -1, 11, -1, -1);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick(4'b0000, "abort_start_idle0");
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick(4'b0000, "abort_start_idle1");
        tick(4'b0000, "abort_start_idle2");

        run("rst_rdy", 4, 3, 10, 19, -1, -1, 5, -1);
        run("max_ready", 0, 255, 1, 258, -1, -1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            int l, r, p;
            l = $urandom_range(0, 5);
            r = $urandom_range(0, 5);
            p = $urandom_range(0, 5);
            run($sformatf("rnd%0d", i), l, r, p, l + (r == 0 ? 1 : r) + (p == 0 ? 1 : p) + 2,
                -1, -1, -1, -1);
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ready_seq_gen.md
Name: ready_seq_gen

Overview:
- Upstream stimulus/control stage that produces the `ready` / `readyp` handshake pair consumed by the downstream ready-then-wait-for-readyp stage.
- On a `start` pulse it runs one programmable sequence:
  - idle lead-in (`ready`=0, `readyp`=0),
  - `ready` window,
  - `readyp` window,
  - one-cycle `done` pulse, then back to idle.
- Replaces hand-written repeat(N)@(posedge clk) stimulus with a reusable, timing-exact sequencer.

Parameters:
- CNT_W, 8, width of all length/count fields; max phase length 2**CNT_W-1 cycles.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to launch a sequence; sampled only in IDLE.
- abort  input  1  cancel the running sequence; highest priority.
- lead_cycles  input  CNT_W  cycles from start edge to `ready` rise (0 allowed).
- ready_len  input  CNT_W  cycles `ready` is high; 0 treated as 1.
- readyp_len  input  CNT_W  cycles `readyp` is high; 0 treated as 1.
- ready  output  1  registered ready to downstream stage.
- readyp  output  1  registered readyp to downstream stage.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=IDLE;
  - `ready`=0, `readyp`=0, `busy`=0, `done`=0;
  - counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, LEAD, RDY, RDYP.
- Config capture: `lead_cycles`, `ready_len` and `readyp_len` are latched at the accepting start edge. Later changes have no effect until the next start.
- Timing, with start accepted at edge N, L=lead_cycles, R=max(ready_len,1), P=max(readyp_len,1):
  - `busy` set at edge N.
  - `ready` set at edge N+L. With L=0, `ready` is set at edge N itself, going IDLE->RDY directly.
  - `ready` cleared and `readyp` set at edge N+L+R (RDY->RDYP). The two are never high together.
  - `readyp` cleared, `busy` cleared and `done` set at edge N+L+R+P (RDYP->IDLE).
  - `done` cleared at the next edge.
- Transitions:
  - IDLE->LEAD on start with L>0.
  - IDLE->RDY on start with L=0.
  - LEAD->RDY when the count expires.
  - RDY->RDYP when the count expires.
  - RDYP->IDLE when the count expires.
- Counter: a down counter loaded with the phase length at phase entry; the phase ends on the edge where the counter reaches 1. All length arithmetic is CNT_W wide, with no wrap, because loads never exceed 2**CNT_W-1.
- start while busy: ignored; no queueing.
- start in the `done` cycle: accepted, since the block is back in IDLE. `done` still deasserts at that edge.
- abort (any non-IDLE state):
  - at the next edge, state=IDLE and `ready`/`readyp`/`busy`=0;
  - `done` is NOT pulsed.
- abort and start together in IDLE: abort wins; start is dropped.
- rst_n=0 mid-sequence: identical to the reset values above. Reset overrides abort and start.

Optional Feature:
- Macro: READY_HOLD_EN.
- Defined: `ready` stays high through the RDYP phase and falls together with `readyp` at edge N+L+R+P. This models an upstream that holds ready until readyp completes.
- Undefined: `ready` and `readyp` are mutually exclusive, as described in Behaviour.
- `done`/`busy` timing is identical in both cases.

Decomposition:
- Package ready_seq_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, LEAD, RDY, RDYP};
  - default CNT_W localparam;
  - function len_sat1(), returning max(x,1).
- Sub-module phase_counter:
  - CNT_W-wide loadable down counter;
  - ports: clk, rst_n, load, load_val, en, expire (expire = count==1 while en).
- Top FSM instantiates one phase_counter.

Test Plan:
- Reset → all outputs 0. Start at edge 1 with L=4, R=3, P=10 → `ready` high after edges 5..7, `readyp` high after edges 8..17, `done` set at edge 18 for one cycle, `busy` high after edges 1..17.
- L=0, R=0, P=0 → `ready` set at the start edge for 1 cycle, `readyp` for 1 cycle, `done` 2 edges after start.
- Start pulsed again at edge 3 of a running sequence → ignored, timing unchanged. Start in the `done` cycle → new sequence begins at that edge.
- Abort during RDYP (edge 12 of the first scenario) → `ready`/`readyp`/`busy`=0 after edge 12, no `done`. Abort+start together in IDLE → nothing launches.
- rst_n=0 for one edge during RDY → all outputs 0 next cycle. Config inputs changed mid-sequence → no effect.
- With READY_HOLD_EN and the first scenario's config → `ready` high after edges 5..17, falling with `readyp` at edge 18.
